// File: rtl/karatsuba_dot_accumulator.sv
// Accumulate half of the MAC datapath: sums a programmed number of unsigned
// products from the Karatsuba multiplier and hands the wide result downstream.
module karatsuba_dot_accumulator #(
   parameter int unsigned PROD_W = 64,
   parameter int unsigned ACC_W  = 72,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  len,
   input  logic              prod_valid,
   input  logic [PROD_W-1:0] prod_data,
   output logic              prod_ready,
   output logic              acc_valid,
   output logic [ACC_W-1:0]  acc_data,
   input  logic              acc_ready,
   output logic              overflow,
   output logic              busy
);

   localparam int unsigned SUM_W = ACC_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               ovf_q, ovf_d;
   logic [SUM_W-1:0]   sum;

   // Extra top bit of the sum is the carry out that feeds the sticky overflow.
   assign sum = {1'b0, acc_q} + SUM_W'(prod_data);

   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      rem_d      = rem_q;
      ovf_d      = ovf_q;
      prod_ready = 1'b0;
      acc_valid  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               rem_d   = len;
               state_d = (len == '0) ? S_HOLD : S_ACCUM;
            end
         end
         S_ACCUM: begin
            prod_ready = 1'b1;
            if (prod_valid) begin
               acc_d = sum[ACC_W-1:0];
               ovf_d = ovf_q | sum[ACC_W];
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            acc_valid = 1'b1;
            if (acc_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         rem_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         rem_q   <= rem_d;
         ovf_q   <= ovf_d;
      end
   end

   assign acc_data = acc_q;
   assign overflow = ovf_q;
   assign busy     = (state_q != S_IDLE);

endmodule
